alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_core.sv | 47 ++++
 rtl/alu_ctrl.sv | 111 +++++++++++
 tb/tb_alu_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the Y86-64 OPq ALU controller.
package alu_pkg;

  // OPq function codes; any other ifun value is illegal
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_XOR = 4'd3;

  // Controller FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit positions inside cc = {ZF, SF, OF}
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  // Condition codes after reset: ZF set, SF and OF clear
  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational OPq datapath. SUB reuses the adder by
// feeding ~val_a with a carry-in of 1; the adder carry-out is dropped.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [3:0]       ifun_i,
  input  logic [WIDTH-1:0] val_a_i,
  input  logic [WIDTH-1:0] val_b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zf_o,
  output logic             sf_o,
  output logic             of_o,
  output logic             illegal_o
);

  logic signed [WIDTH-1:0] opa;
  logic signed [WIDTH-1:0] opb;
  logic signed [WIDTH-1:0] sum;
  logic                    is_sub;

  // Shared adder, result select and flag generation
  always_comb begin
    is_sub    = (ifun_i == ALU_SUB);
    opb       = val_b_i;
    opa       = is_sub ? ~val_a_i : val_a_i;
    sum       = opb + opa + {{(WIDTH-1){1'b0}}, is_sub};
    result_o  = '0;
    of_o      = 1'b0;
    illegal_o = 1'b0;
    case (ifun_i)
      ALU_ADD, ALU_SUB: begin
        result_o = sum;
        // Same-sign adder inputs producing a different-sign sum; with opa
        // already inverted for SUB this is exactly the subtract overflow.
        of_o     = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opb[WIDTH-1]);
      end
      ALU_AND: result_o = val_b_i & val_a_i;
      ALU_XOR: result_o = val_b_i ^ val_a_i;
      default: illegal_o = 1'b1;
    endcase
    zf_o = (result_o == '0);
    sf_o = result_o[WIDTH-1];
  end

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: IDLE -> EXEC -> DONE controller around alu_core. Captures one
// request, computes it in EXEC and holds registered results until consumed.
module alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ifun,
  input  logic [WIDTH-1:0] val_a,
  input  logic [WIDTH-1:0] val_b,
  input  logic             set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] val_e,
  output logic [2:0]       cc,
  output logic             err
);

  state_e           state_q, state_d;
  logic [3:0]       ifun_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             set_cc_q;
  logic [WIDTH-1:0] val_e_q, val_e_d;
  logic [2:0]       cc_q, cc_d;
  logic             err_q, err_d;
  logic             accept;

  logic [WIDTH-1:0] core_result;
  logic             core_zf, core_sf, core_of, core_illegal;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign val_e     = val_e_q;
  assign cc        = cc_q;
  assign err       = err_q;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .ifun_i    (ifun_q),
    .val_a_i   (a_q),
    .val_b_i   (b_q),
    .result_o  (core_result),
    .zf_o      (core_zf),
    .sf_o      (core_sf),
    .of_o      (core_of),
    .illegal_o (core_illegal)
  );

  // Next state: accept in IDLE, one cycle of EXEC, wait for consumer in DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset wins over any handshake and aborts the operation
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Operand capture on acceptance so later input changes cannot leak in
  always_ff @(posedge clk) begin
    if (accept) begin
      ifun_q   <= ifun;
      a_q      <= val_a;
      b_q      <= val_b;
      set_cc_q <= set_cc;
    end
  end

  // Result registers change only in EXEC; cc only for legal set_cc requests
  always_comb begin
    val_e_d = val_e_q;
    cc_d    = cc_q;
    err_d   = err_q;
    if (state_q == ST_EXEC) begin
      val_e_d = core_result;
      err_d   = core_illegal;
      if (set_cc_q && !core_illegal) begin
        cc_d[CC_ZF] = core_zf;
        cc_d[CC_SF] = core_sf;
        cc_d[CC_OF] = core_of;
      end
    end
  end

  // Output registers with architectural reset values
  always_ff @(posedge clk) begin
    if (rst) begin
      val_e_q <= '0;
      cc_q    <= CC_RESET;
      err_q   <= 1'b0;
    end else begin
      val_e_q <= val_e_d;
      cc_q    <= cc_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: vector table plus random and hand-written sequences with a
// queue-based scoreboard for alu_ctrl (WIDTH = 64).
module tb_alu_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ifun;
  logic [63:0] val_a;
  logic [63:0] val_b;
  logic        set_cc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] val_e;
  logic [2:0]  cc;
  logic        err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] v;
    logic [2:0]  cc;
    logic        err;
  } exp_t;

  typedef struct {
    logic [3:0]  f;
    logic [63:0] a;
    logic [63:0] b;
    logic        sc;
    logic [63:0] ev;
    logic [2:0]  ecc;
    logic        ee;
    int          hold;
    logic        early;
  } vec_t;

  exp_t        sbq[$];
  vec_t        tbl[10];
  logic [2:0]  cc_m;

  alu_ctrl #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ifun      (ifun),
    .val_a     (val_a),
    .val_b     (val_b),
    .set_cc    (set_cc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .val_e     (val_e),
    .cc        (cc),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached, required run completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Reference model: overflow from a 65-bit signed sum, cc tracked in cc_m
  function automatic void model(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                                input logic sc, output logic [63:0] v, output logic e);
    logic signed [64:0] wide;
    logic ovf;
    v = '0; e = 1'b0; ovf = 1'b0; wide = '0;
    case (f)
      4'd0: begin
        wide = $signed({b[63], b}) + $signed({a[63], a});
        v = wide[63:0]; ovf = (wide[64] != wide[63]);
      end
      4'd1: begin
        wide = $signed({b[63], b}) - $signed({a[63], a});
        v = wide[63:0]; ovf = (wide[64] != wide[63]);
      end
      4'd2: v = b & a;
      4'd3: v = b ^ a;
      default: e = 1'b1;
    endcase
    if (!e && sc) cc_m = {(v == 64'd0), v[63], ovf};
  endfunction

  // One request: accept, scramble inputs in EXEC, check latency and result,
  // optionally stall the consumer for `hold` cycles, then consume.
  task automatic run_op(input logic [3:0] f, input logic [63:0] a, input logic [63:0] b,
                        input logic sc, input logic [63:0] ev, input logic [2:0] ecc,
                        input logic ee, input int hold, input logic early);
    exp_t e;
    int   lat;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    ifun = f; val_a = a; val_b = b; set_cc = sc; in_valid = 1'b1; out_ready = early;
    e.v = ev; e.cc = ecc; e.err = ee;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; ifun = ~f; val_a = ~a; val_b = ~b; set_cc = ~sc;
    chk("exec_out_valid", 64'(out_valid), 64'd0);
    chk("exec_in_ready", 64'(in_ready), 64'd0);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 64'(lat), 64'd2);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (out_valid) begin
        chk("val_e", val_e, e.v);
        chk("cc", 64'(cc), 64'(e.cc));
        chk("err", 64'(err), 64'(e.err));
      end
    end
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_val_e", val_e, e.v);
      chk("hold_cc", 64'(cc), 64'(e.cc));
      chk("hold_err", 64'(err), 64'(e.err));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({nm, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_val_e"}, val_e, 64'd0);
    chk({nm, "_cc"}, 64'(cc), 64'(3'b100));
    chk({nm, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    logic [63:0] ra, rb, ev;
    logic        ee, sc;
    logic [3:0]  f;
    int          nacc, last, cyc;
    exp_t        e;

    tbl[0] = '{4'd0, 64'd11, 64'd4, 1'b1, 64'd15, 3'b000, 1'b0, 0, 1'b0};
    tbl[1] = '{4'd0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000, 3'b011, 1'b0, 0, 1'b0};
    tbl[2] = '{4'd1, 64'd5, 64'd5, 1'b1, 64'd0, 3'b100, 1'b0, 0, 1'b1};
    tbl[3] = '{4'd3, 64'hF, 64'hF, 1'b0, 64'd0, 3'b100, 1'b0, 0, 1'b0};
    tbl[4] = '{4'd1, 64'd1, 64'h8000_0000_0000_0000, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 3'b001, 1'b0, 0, 1'b0};
    tbl[5] = '{4'd2, 64'hFFFF_FFFF_0000_0000, 64'h8000_0000_0000_00FF, 1'b1, 64'h8000_0000_0000_0000, 3'b010, 1'b0, 0, 1'b0};
    tbl[6] = '{4'd7, 64'd3, 64'd4, 1'b1, 64'd0, 3'b010, 1'b1, 5, 1'b0};
    tbl[7] = '{4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'd0, 3'b100, 1'b0, 0, 1'b0};
    tbl[8] = '{4'd1, 64'd1, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 3'b100, 1'b0, 0, 1'b0};
    tbl[9] = '{4'd15, 64'd9, 64'd9, 1'b0, 64'd0, 3'b100, 1'b1, 2, 1'b1};

    rst = 1'b1; in_valid = 1'b0; ifun = 4'd0; val_a = '0; val_b = '0;
    set_cc = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    cc_m = 3'b100;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].sc, tbl[i].ev, tbl[i].ecc,
             tbl[i].ee, tbl[i].hold, tbl[i].early);
      cc_m = tbl[i].ecc;
    end

    // Random requests, including boundary operands and illegal codes
    for (int i = 0; i < 12; i++) begin
      f  = 4'($urandom_range(0, 5));
      sc = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: ra = 64'h8000_0000_0000_0000;
        1: ra = 64'h7FFF_FFFF_FFFF_FFFF;
        default: ra = {$urandom, $urandom};
      endcase
      rb = (i % 3 == 0) ? ra : {$urandom, $urandom};
      model(f, ra, rb, sc, ev, ee);
      run_op(f, ra, rb, sc, ev, cc_m, ee, 0, 1'b0);
    end

    // Back-to-back: in_valid and out_ready held high
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b0;
    nacc = 0; last = -1; cyc = 0;
    while (cyc < 40 && (nacc < 4 || sbq.size() > 0)) begin
      if (nacc >= 4) in_valid = 1'b0;
      if (out_valid) begin
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("b2b_val_e", val_e, e.v);
          chk("b2b_cc", 64'(cc), 64'(e.cc));
          chk("b2b_err", 64'(err), 64'(e.err));
        end else begin
          chk("b2b_unexpected_out", 64'(out_valid), 64'd0);
        end
      end
      if (in_ready && nacc < 4) begin
        if (last >= 0) chk("b2b_spacing", 64'(cyc - last), 64'd3);
        last = cyc;
        f  = 4'(nacc % 4);
        ra = {$urandom, $urandom};
        rb = 64'(nacc * 1000 + 7);
        ifun = f; val_a = ra; val_b = rb; set_cc = 1'b1; in_valid = 1'b1;
        model(f, ra, rb, 1'b1, ev, ee);
        e.v = ev; e.cc = cc_m; e.err = ee;
        sbq.push_back(e);
        nacc++;
      end
      @(negedge clk);
      cyc++;
    end
    chk("b2b_accepts", 64'(nacc), 64'd4);
    chk("b2b_drained", 64'(sbq.size()), 64'd0);
    in_valid = 1'b0; out_ready = 1'b0;
    sbq.delete();

    // Reset during EXEC, with in_valid also high on the reset edge
    @(negedge clk);
    ifun = 4'd0; val_a = 64'd11; val_b = 64'd4; set_cc = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rexec_in_exec", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    check_reset_state("rst_exec");

    // Reset in DONE while the consumer is ready
    ifun = 4'd1; val_a = 64'd2; val_b = 64'd9; set_cc = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rdone_out_valid", 64'(out_valid), 64'd1);
    chk("rdone_val_e", val_e, 64'd7);
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    check_reset_state("rst_done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
